// File: rtl/keypad_event_generator_pkg.sv
// Shared types and constants for the keypad event generator and its top-level wiring.
package keypad_event_generator_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } keypad_state_t;

  localparam logic [3:0] KEY_FLIPPER_SINGLE = 4'd4;
  localparam logic [3:0] KEY_FLIPPER_DUAL   = 4'd6;

  function automatic logic [15:0] key_onehot(input logic [3:0] code);
    key_onehot = 16'h0001 << code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous raw inputs; reusable at any width.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_event_generator.sv
// Debounces raw keypad decoder outputs into one-cycle press/repeat pulses and a held level.
module keypad_event_generator
  import keypad_event_generator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES      = 500_000,
  parameter bit          REPEAT_EN            = 1'b0,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keyCode,
  input  logic        keyValid,
  output logic [15:0] keyPulse,
  output logic [15:0] keyLevel
);

  localparam int unsigned MaxDr = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                                  DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
  localparam int unsigned MaxCycles = (MaxDr > REPEAT_PERIOD_CYCLES) ?
                                      MaxDr : REPEAT_PERIOD_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] CntMax        = '1;
  localparam logic [CntW-1:0] DebLast       = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] RepDelayLast  = CntW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CntW-1:0] RepPeriodLast = CntW'(REPEAT_PERIOD_CYCLES - 1);

  logic [4:0] sync_raw;
  logic       sync_valid;
  logic [3:0] sync_code;

  sync_2ff #(
    .Width(5)
  ) u_sync (
    .clk_i  (clk),
    .reset_i(reset),
    .d_i    ({keyValid, keyCode}),
    .q_o    (sync_raw)
  );

  assign sync_valid = sync_raw[4];
  assign sync_code  = sync_raw[3:0];

  keypad_state_t state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CntW-1:0] rep_cnt_q, rep_cnt_d;
  logic            rep_phase_q, rep_phase_d;  // 0: waiting initial delay, 1: periodic
  logic [15:0]     pulse_q, pulse_d;

  logic            key_present;
  logic [CntW-1:0] deb_inc;
  logic [CntW-1:0] rep_inc;
  logic [CntW-1:0] rep_last;

  assign key_present = sync_valid && (sync_code == cand_q);
  assign deb_inc     = (deb_cnt_q == CntMax) ? deb_cnt_q : deb_cnt_q + CntW'(1);
  assign rep_inc     = (rep_cnt_q == CntMax) ? rep_cnt_q : rep_cnt_q + CntW'(1);
  assign rep_last    = rep_phase_q ? RepPeriodLast : RepDelayLast;

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_cnt_d   = deb_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    pulse_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (sync_valid) begin
          cand_d    = sync_code;
          deb_cnt_d = '0;
          state_d   = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!sync_valid) begin
          state_d = IDLE;
        end else if (sync_code != cand_q) begin
          cand_d    = sync_code;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DebLast) begin
          state_d     = HELD;
          pulse_d     = key_onehot(cand_q);
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      HELD: begin
        if (!key_present) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (REPEAT_EN) begin
          if (rep_cnt_q == rep_last) begin
            pulse_d     = key_onehot(cand_q);
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        // A return of the same key is a bounce: resume holding, repeat timing restarts.
        if (key_present) begin
          state_d     = HELD;
          rep_cnt_d   = '0;
          rep_phase_d = 1'b0;
        end else if (deb_cnt_q == DebLast) begin
          state_d = IDLE;
        end else begin
          deb_cnt_d = deb_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
      pulse_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
      pulse_q     <= pulse_d;
    end
  end

  always_comb begin
    keyLevel = '0;
    if (state_q == HELD || state_q == RELEASE_WAIT) begin
      keyLevel = key_onehot(cand_q);
    end
  end

  assign keyPulse = pulse_q;

endmodule

// File: tb/tb_keypad_event_generator.sv
// Randomized scoreboard bench for keypad_event_generator against a run-length reference model.
module tb_keypad_event_generator;

  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic [15:0] keyPulse;
  logic [15:0] keyLevel;

  always #5 clk = ~clk;

  keypad_event_generator #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_EN           (1'b1),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .keyCode (keyCode),
    .keyValid(keyValid),
    .keyPulse(keyPulse),
    .keyLevel(keyLevel)
  );

  typedef struct {
    int          cyc;
    logic [15:0] val;
  } ev_t;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          done = 1'b0;
  logic [15:0] exp_level = '0;

  // Reference model: raw inputs reach the decision logic two edges late; a press is
  // accepted after D+1 consecutive identical valid samples, a release after D+1
  // consecutive samples without the held key; repeats are timed from entry into holding.
  logic [4:0] m_d1, m_d2;
  bit         m_held;
  logic [3:0] m_hcode, m_rcode;
  int         m_run, m_abs, m_t;

  always @(posedge clk) begin : model
    logic        sv;
    logic [3:0]  sc;
    logic [15:0] pls;
    cyc = cyc + 1;
    pls = '0;
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_held = 1'b0; m_hcode = '0; m_rcode = '0;
      m_run = 0; m_abs = 0; m_t = 0;
    end else begin
      sv   = m_d2[4];
      sc   = m_d2[3:0];
      m_d2 = m_d1;
      m_d1 = {keyValid, keyCode};
      if (!m_held) begin
        if (sv) begin
          if (m_run > 0 && sc == m_rcode) m_run = m_run + 1;
          else begin
            m_run   = 1;
            m_rcode = sc;
          end
          if (m_run == D + 1) begin
            m_held  = 1'b1;
            m_hcode = m_rcode;
            m_t     = 0;
            m_abs   = 0;
            pls     = 16'h0001 << m_rcode;
          end
        end else begin
          m_run = 0;
        end
      end else if (sv && sc == m_hcode) begin
        if (m_abs > 0) begin
          m_abs = 0;
          m_t   = 0;
        end else begin
          m_t = m_t + 1;
          if (m_t == RD || (m_t > RD && (m_t - RD) % RP == 0)) pls = 16'h0001 << m_hcode;
        end
      end else begin
        m_abs = m_abs + 1;
        if (m_abs == D + 1) begin
          m_held = 1'b0;
          m_run  = 0;
          m_abs  = 0;
        end
      end
    end
    exp_level = m_held ? (16'h0001 << m_hcode) : 16'h0000;
    if (pls != 16'h0000) exp_q.push_back('{cyc, pls});
  end

  always @(negedge clk) begin : monitor
    if (!done) begin
      tests = tests + 1;
      if (keyLevel !== exp_level) begin
        fails = fails + 1;
        $display("FAIL level cyc=%0d got=%h exp=%h", cyc, keyLevel, exp_level);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL missed_pulse cyc=%0d got=0000 exp=%h (due cyc %0d)",
                 cyc, exp_q[0].val, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (keyPulse !== 16'h0000) begin
        tests = tests + 1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          if (keyPulse !== exp_q[0].val) begin
            fails = fails + 1;
            $display("FAIL pulse cyc=%0d got=%h exp=%h", cyc, keyPulse, exp_q[0].val);
          end
          void'(exp_q.pop_front());
        end else begin
          fails = fails + 1;
          $display("FAIL spurious_pulse cyc=%0d got=%h exp=0000", cyc, keyPulse);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      keyValid = v;
      keyCode  = c;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    keyValid = 1'b0;
    keyCode  = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 4'd0, 5);
    // Clean press of key 4, then release.
    drive(1'b1, 4'd4, 30);
    drive(1'b0, 4'd4, 20);
    // Bouncing valid, then key 6 held long enough for auto-repeat.
    for (int i = 0; i < 4; i++) drive((i % 2) == 0, 4'd6, 1);
    drive(1'b1, 4'd6, 40);
    drive(1'b0, 4'd0, 20);
    // Short release glitch while holding key 4.
    drive(1'b1, 4'd4, 20);
    drive(1'b0, 4'd4, 2);
    drive(1'b1, 4'd4, 20);
    drive(1'b0, 4'd0, 20);
    // Direct change from key 4 to key 6.
    drive(1'b1, 4'd4, 20);
    drive(1'b1, 4'd6, 30);
    drive(1'b0, 4'd0, 20);
    // Reset while key 4 is held.
    drive(1'b1, 4'd4, 20);
    pulse_reset();
    drive(1'b1, 4'd4, 20);
    drive(1'b0, 4'd0, 20);
    // Random segments: bursts, bounces, code changes, occasional reset.
    for (int s = 0; s < 200; s++) begin
      logic       v;
      logic [3:0] c;
      int         n;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 6));
      n = $urandom_range(1, 14);
      if ($urandom_range(0, 29) == 0) pulse_reset();
      drive(v, c, n);
    end
    drive(1'b0, 4'd0, 30);
    @(negedge clk);
    done = 1'b1;
    tests = tests + 1;
    if (exp_q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL pending_pulses got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
